// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with valid/ready in/out
// handshakes and a 2-entry skid buffer (main register drives out_*).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;
  localparam logic [2:0] TYPE_Z = 3'd6;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  // Sign-extend a 32-bit value to XLEN using its bit 31.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Form the immediate for one instruction according to its decoded type.
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr,
                                               input logic [2:0]  typ);
    logic [XLEN-1:0] r;
    logic [6:0]      opc;
    logic            is_shift;
    r        = '0;
    opc      = instr[6:0];
    is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);
    case (typ)
      TYPE_I: begin
        if ((opc == OPC_OP_IMM) && is_shift) begin
          r[SHAMT_W-1:0] = instr[20 +: SHAMT_W];
        end else if ((XLEN == 64) && (opc == OPC_OP_IMM_32) && is_shift) begin
          r[4:0] = instr[24:20];
        end else begin
          r = sext32({{20{instr[31]}}, instr[31:20]});
        end
      end
      TYPE_S: r = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
      TYPE_B: r = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0});
      TYPE_U: r = sext32({instr[31:12], 12'b0});
      TYPE_J: r = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0});
      TYPE_Z: r[4:0] = instr[19:15];
      default: r = '0;
    endcase
    return r;
  endfunction

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [2:0]       main_type_q,  main_type_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [2:0]       skid_type_q,  skid_type_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  logic [XLEN-1:0]  in_imm;
  logic             accept;
  logic             main_free;

  // in_ready comes straight from the skid valid flop: no path from out_ready.
  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & ~skid_valid_q;
  assign main_free = ~main_valid_q | out_ready;
  assign in_imm    = gen_imm(in_instr, in_type);

  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign out_type  = main_type_q;
  assign out_tag   = main_tag_q;

  // Next-state for main/skid: refill main from skid first to keep FIFO order.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_type_d  = main_type_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_type_d  = skid_type_q;
    skid_tag_d   = skid_tag_q;
    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_type_d  = skid_type_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_imm_d   = in_imm;
        main_type_d  = in_type;
        main_tag_d   = in_tag;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = in_imm;
        skid_type_d  = in_type;
        skid_tag_d   = in_tag;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // State registers: reset clears everything, flush only drops the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_type_q  <= 3'd0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_type_q  <= 3'd0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d & ~flush;
      main_imm_q   <= main_imm_d;
      main_type_q  <= main_type_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d & ~flush;
      skid_imm_q   <= skid_imm_d;
      skid_type_q  <= skid_type_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share all inputs;
// expected entries are queued on acceptance and checked when consumed.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [2:0]  in_type = 3'd0;
  logic [31:0] in_tag = 32'h0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, in_ready64, out_valid64;
  logic [31:0] out_imm, out_tag, out_tag64;
  logic [63:0] out_imm64;
  logic [2:0]  out_type, out_type64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_type(out_type), .out_tag(out_tag));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_type(out_type64), .out_tag(out_tag64));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic [31:0] e32;
    logic [63:0] e64;
  } vec_t;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  typ;
    logic [31:0] tag;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[16];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] cur_e32 = 32'h0;
  logic [63:0] cur_e64 = 64'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard: pop/compare on consumption, push on acceptance, drop on rst/flush.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got tag %h required no entry", out_tag);
        end else begin
          e = sbq.pop_front();
          chk("out_imm32", {32'h0, out_imm}, {32'h0, e.e32});
          chk("out_imm64", out_imm64, e.e64);
          chk("out_type", {61'h0, out_type}, {61'h0, e.typ});
          chk("out_tag", {32'h0, out_tag}, {32'h0, e.tag});
          chk("out_valid64", {63'h0, out_valid64}, 64'h1);
        end
      end
      if (in_valid && in_ready) begin
        e.e32 = cur_e32;
        e.e64 = cur_e64;
        e.typ = in_type;
        e.tag = in_tag;
        sbq.push_back(e);
      end
    end
  end

  // Offer one entry; returns at posedge+1 after it was accepted (in_valid low).
  task automatic send(input logic [31:0] instr, input logic [2:0] typ, input logic [31:0] tag,
                      input logic [31:0] e32, input logic [63:0] e64);
    int n;
    in_instr = instr;
    in_type  = typ;
    in_tag   = tag;
    cur_e32  = e32;
    cur_e64  = e64;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_empty(input string name);
    chk({name, "_out_valid"}, {63'h0, out_valid}, 64'h0);
    chk({name, "_in_ready"}, {63'h0, in_ready}, 64'h1);
  endtask

  initial begin
    int t0;
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[1]  = '{32'h7FF00093, 3'd1, 32'h000007FF, 64'h00000000000007FF};
    vecs[2]  = '{32'h43F0D093, 3'd1, 32'h0000001F, 64'h000000000000003F};
    vecs[3]  = '{32'hFFF11083, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[4]  = '{32'h83F0909B, 3'd1, 32'hFFFFF83F, 64'h000000000000001F};
    vecs[5]  = '{32'h02009093, 3'd1, 32'h00000000, 64'h0000000000000020};
    vecs[6]  = '{32'hFE20AE23, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
    vecs[7]  = '{32'h00112423, 3'd2, 32'h00000008, 64'h0000000000000008};
    vecs[8]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
    vecs[9]  = '{32'h00000463, 3'd3, 32'h00000008, 64'h0000000000000008};
    vecs[10] = '{32'h80000037, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000};
    vecs[11] = '{32'h12345037, 3'd4, 32'h12345000, 64'h0000000012345000};
    vecs[12] = '{32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
    vecs[13] = '{32'h340FD073, 3'd6, 32'h0000001F, 64'h000000000000001F};
    vecs[14] = '{32'hFFFFFFFF, 3'd0, 32'h00000000, 64'h0000000000000000};
    vecs[15] = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_empty("reset");
    chk("reset_out_imm", {32'h0, out_imm}, 64'h0);
    chk("reset_out_type", {61'h0, out_type}, 64'h0);
    chk("reset_out_tag", {32'h0, out_tag}, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // One-cycle latency from acceptance
    out_ready = 1'b1;
    send(vecs[0].instr, vecs[0].typ, 32'hAAAA0000, vecs[0].e32, vecs[0].e64);
    chk("latency_out_valid", {63'h0, out_valid}, 64'h1);
    chk("latency_out_imm", {32'h0, out_imm}, {32'h0, vecs[0].e32});
    @(posedge clk);
    #1;
    chk("drain_out_valid", {63'h0, out_valid}, 64'h0);

    // Table stream at full throughput with out_ready held high
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].instr, vecs[i].typ, 32'h1000 + i, vecs[i].e32, vecs[i].e64);
    end
    chk("throughput_cycles", 64'(cyc - t0), 64'd16);
    @(posedge clk);
    #1;
    chk("stream_drained_valid", {63'h0, out_valid}, 64'h0);
    chk("stream_sb_empty", 64'(sbq.size()), 64'd0);

    // Backpressure: A, B fill both entries; C stalls until space frees
    out_ready = 1'b0;
    send(vecs[0].instr, vecs[0].typ, 32'h0000000A, vecs[0].e32, vecs[0].e64);
    send(vecs[10].instr, vecs[10].typ, 32'h0000000B, vecs[10].e32, vecs[10].e64);
    in_instr = vecs[12].instr;
    in_type  = vecs[12].typ;
    in_tag   = 32'h0000000C;
    cur_e32  = vecs[12].e32;
    cur_e64  = vecs[12].e64;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'h0, in_ready}, 64'h0);
      chk("stall_out_valid", {63'h0, out_valid}, 64'h1);
      chk("stall_out_tag", {32'h0, out_tag}, 64'h0000000A);
      chk("stall_out_imm", {32'h0, out_imm}, {32'h0, vecs[0].e32});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {63'h0, in_ready}, 64'h1);
    chk("release_out_tag_b", {32'h0, out_tag}, 64'h0000000B);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("release_out_tag_c", {32'h0, out_tag}, 64'h0000000C);
    @(posedge clk);
    #1;
    chk("bp_drained_valid", {63'h0, out_valid}, 64'h0);
    chk("bp_sb_empty", 64'(sbq.size()), 64'd0);

    // Flush with two entries held and an input offered
    out_ready = 1'b0;
    send(vecs[1].instr, vecs[1].typ, 32'h00000F01, vecs[1].e32, vecs[1].e64);
    send(vecs[2].instr, vecs[2].typ, 32'h00000F02, vecs[2].e32, vecs[2].e64);
    in_instr = vecs[3].instr; in_type = vecs[3].typ; in_tag = 32'h0000DEAD;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_empty("flush2");
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush2_no_output", {63'h0, out_valid}, 64'h0);
    end

    // Flush with one entry held: in_ready is high, offered input still dropped
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(vecs[4].instr, vecs[4].typ, 32'h00000F03, vecs[4].e32, vecs[4].e64);
    in_instr = vecs[5].instr; in_type = vecs[5].typ; in_tag = 32'h0000BEEF;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_empty("flush1");
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush1_no_output", {63'h0, out_valid}, 64'h0);
    end

    // Reset (with flush also high) mid-transfer clears everything
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(vecs[0].instr, vecs[0].typ, 32'h00000E01, vecs[0].e32, vecs[0].e64);
    send(vecs[12].instr, vecs[12].typ, 32'h00000E02, vecs[12].e32, vecs[12].e64);
    in_instr = vecs[6].instr; in_type = vecs[6].typ; in_tag = 32'h0000CAFE;
    in_valid = 1'b1;
    rst = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    check_empty("rst_mid");
    chk("rst_mid_out_imm", {32'h0, out_imm}, 64'h0);
    chk("rst_mid_out_type", {61'h0, out_type}, 64'h0);
    chk("rst_mid_out_tag", {32'h0, out_tag}, 64'h0);
    chk("rst_mid_out_imm64", out_imm64, 64'h0);
    chk("rst_mid_out_valid64", {63'h0, out_valid64}, 64'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_output", {63'h0, out_valid}, 64'h0);
    end
    chk("final_sb_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
